// File: rtl/seg_disp_pkg.sv
// Shared constants and state encoding for the seven-segment display arbiter.
package seg_disp_pkg;

    localparam int DIGITS = 8;
    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [DIGITS*8-1:0] BLANK_SEG = {DIGITS{BLANK_CHAR}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_vec_i searching
// upward from last_idx_i + 1, wrapping at N.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req_vec_i,
    input  logic [$clog2(N)-1:0] last_idx_i,
    output logic [N-1:0]         grant_oh_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_idx_i) + k) % N);
            if (!found && req_vec_i[idx]) begin
                found           = 1'b1;
                grant_oh_o[idx] = 1'b1;
                grant_idx_o     = idx;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the 8-digit display between a background source and NUM_REQ
// message requesters: round-robin grant, fixed hold, blank gap between messages.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [DIGITS*8-1:0]     base_seg,
    input  logic [DIGITS-1:0]       base_point,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*64-1:0]   req_seg,
    input  logic [NUM_REQ*8-1:0]    req_point,
    output logic [DIGITS*8-1:0]     assic_seg,
    output logic [DIGITS-1:0]       seg_point,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic                    busy,
    output state_e                  dbg_state
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_REQ);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [DIGITS*8-1:0]  seg_q, seg_d;
    logic [DIGITS-1:0]    point_q, point_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    logic [NUM_REQ-1:0]   req_all, others_pend, pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid, owner_refresh, hold_end, take;

    // req[i] is a one-cycle pulse; the slot's data must stay stable until the
    // cycle in which grant[i] is decided, which is when it gets sampled.
    assign req_all       = pending_q | req;
    assign others_pend   = pending_q | (req & ~grant_q);
    assign owner_refresh = (state_q == ST_SHOW) && req[owner_q];
    assign hold_end      = (state_q == ST_SHOW) && !owner_refresh && (cnt_q == '0);
    assign take          = pick_valid &&
                           ((state_q == ST_IDLE) || (state_q == ST_GAP && cnt_q == '0));

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_vec_i   (req_all),
        .last_idx_i  (last_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx),
        .valid_o     (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            owner_q   <= '0;
            seg_q     <= BLANK_SEG;
            point_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            seg_q     <= seg_d;
            point_q   <= point_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_SHOW;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_SHOW: begin
                if (owner_refresh) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = (others_pend != '0) ? ST_GAP : ST_IDLE;
                    cnt_d   = (others_pend != '0) ? GAP_LOAD : '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = pick_valid ? ST_SHOW : ST_IDLE;
                    cnt_d   = pick_valid ? HOLD_LOAD : '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Display content follows the state being entered, so it lines up with grant.
    always_comb begin
        pending_d = others_pend;
        last_d    = last_q;
        owner_d   = owner_q;
        seg_d     = seg_q;
        point_d   = point_q;
        grant_d   = grant_q;
        done_d    = hold_end ? grant_q : '0;
        if (take) begin
            pending_d = req_all & ~pick_oh;
            last_d    = pick_idx;
            owner_d   = pick_idx;
            seg_d     = req_seg[{pick_idx, 6'b0} +: 64];
            point_d   = req_point[{pick_idx, 3'b0} +: 8];
            grant_d   = pick_oh;
        end else if (state_d == ST_SHOW) begin
            if (owner_refresh) begin
                seg_d   = req_seg[{owner_q, 6'b0} +: 64];
                point_d = req_point[{owner_q, 3'b0} +: 8];
            end
        end else if (state_d == ST_GAP) begin
            seg_d   = BLANK_SEG;
            point_d = '0;
            grant_d = '0;
        end else begin
            seg_d   = base_seg;
            point_d = base_point;
            grant_d = '0;
        end
    end

    assign assic_seg = seg_q;
    assign seg_point = point_q;
    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus a random run checked
// against a remaining-time reference model of the arbitration rules.
module tb_seg_display_arbiter;

    localparam int N    = 3;
    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam logic [63:0] BLANK = {8{8'h20}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn = 1'b0;
    logic [63:0]     base_seg = 64'h0;
    logic [7:0]      base_point = 8'h0;
    logic [N-1:0]    req = '0;
    logic [N*64-1:0] req_seg = '0;
    logic [N*8-1:0]  req_point = '0;
    logic [63:0]     assic_seg;
    logic [7:0]      seg_point;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [1:0]      dbg_state;

    int total = 0;
    int bad   = 0;

    seg_display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .base_seg   (base_seg),
        .base_point (base_point),
        .req        (req),
        .req_seg    (req_seg),
        .req_point  (req_point),
        .assic_seg  (assic_seg),
        .seg_point  (seg_point),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Reference model: owner = -1 when nothing is shown; show_left / gap_left
    // count the display cycles still to go, including the current one.
    int          m_owner, m_show_left, m_gap_left, m_last;
    logic [N-1:0] m_pend;
    logic [63:0] m_cur_seg, e_seg;
    logic [7:0]  m_cur_pt, e_pt;
    logic [N-1:0] e_grant, e_done;
    logic        e_busy;

    task automatic model_pick();
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (m_owner < 0 && m_pend[j]) begin
                m_owner     = j;
                m_last      = j;
                m_pend[j]   = 1'b0;
                m_cur_seg   = req_seg[j*64 +: 64];
                m_cur_pt    = req_point[j*8 +: 8];
                m_show_left = HOLD;
            end
        end
    endtask

    task automatic model_step();
        e_done = '0;
        if (!rstn) begin
            m_owner = -1; m_show_left = 0; m_gap_left = 0; m_last = N - 1; m_pend = '0;
            e_seg = BLANK; e_pt = 8'h0; e_grant = '0; e_busy = 1'b0;
            return;
        end
        if (m_owner >= 0) begin
            for (int i = 0; i < N; i++) if (req[i] && i != m_owner) m_pend[i] = 1'b1;
            if (req[m_owner]) begin
                m_cur_seg   = req_seg[m_owner*64 +: 64];
                m_cur_pt    = req_point[m_owner*8 +: 8];
                m_show_left = HOLD;
            end else begin
                m_show_left--;
                if (m_show_left == 0) begin
                    e_done[m_owner] = 1'b1;
                    m_owner = -1;
                    if (m_pend != '0) m_gap_left = GAP;
                end
            end
        end else if (m_gap_left > 0) begin
            m_pend |= req;
            m_gap_left--;
            if (m_gap_left == 0) model_pick();
        end else begin
            m_pend |= req;
            if (m_pend != '0) model_pick();
        end
        if (m_owner >= 0) begin
            e_seg = m_cur_seg; e_pt = m_cur_pt; e_grant = N'(1 << m_owner); e_busy = 1'b1;
        end else if (m_gap_left > 0) begin
            e_seg = BLANK; e_pt = 8'h0; e_grant = '0; e_busy = 1'b1;
        end else begin
            e_seg = base_seg; e_pt = base_point; e_grant = '0; e_busy = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic load_slot(input int s, input logic [63:0] text, input logic [7:0] pt);
        req_seg[s*64 +: 64] = text;
        req_point[s*8 +: 8] = pt;
    endtask

    task automatic test_reset();
        base_seg = "IDLE-OK ";
        base_point = 8'h81;
        req = '1;
        rstn = 1'b0;
        tick();
        tick();
        req = '0;
        total++; if (assic_seg !== BLANK) begin bad++; $display("FAIL reset_seg got=%h exp=%h", assic_seg, BLANK); end
        total++; if (seg_point !== 8'h00) begin bad++; $display("FAIL reset_point got=%h exp=00", seg_point); end
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=000", grant); end
        total++; if (done !== 3'b000) begin bad++; $display("FAIL reset_done got=%b exp=000", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rstn = 1'b1;
        tick();
        total++; if (assic_seg !== 64'("IDLE-OK ")) begin bad++; $display("FAIL reset_base got=%h", assic_seg); end
        total++; if (seg_point !== 8'h81) begin bad++; $display("FAIL reset_base_point got=%h exp=81", seg_point); end
    endtask

    task automatic test_single();
        do_reset();
        base_seg = "BASE    ";
        load_slot(1, "ERROR   ", 8'h0f);
        req = 3'b010;
        tick();
        req = '0;
        for (int c = 0; c < HOLD; c++) begin
            total++; if (assic_seg !== 64'("ERROR   ")) begin bad++; $display("FAIL single_seg c=%0d got=%h", c, assic_seg); end
            total++; if (grant !== 3'b010 || busy !== 1'b1) begin bad++; $display("FAIL single_grant c=%0d got=%b/%b exp=010/1", c, grant, busy); end
            total++; if (seg_point !== 8'h0f) begin bad++; $display("FAIL single_point c=%0d got=%h exp=0f", c, seg_point); end
            tick();
        end
        total++; if (done !== 3'b010) begin bad++; $display("FAIL single_done got=%b exp=010", done); end
        total++; if (grant !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL single_release got=%b/%b exp=000/0", grant, busy); end
        total++; if (assic_seg !== 64'("BASE    ")) begin bad++; $display("FAIL single_base got=%h", assic_seg); end
        tick();
        total++; if (done !== 3'b000) begin bad++; $display("FAIL single_done_width got=%b exp=000", done); end
    endtask

    task automatic test_simultaneous();
        logic [63:0] msg [N];
        msg[0] = "MSG-ZERO"; msg[1] = "MSG-ONE "; msg[2] = "MSG-TWO ";
        do_reset();
        base_seg = "BACKGRND";
        for (int s = 0; s < N; s++) load_slot(s, msg[s], 8'(s + 1));
        req = 3'b111;
        tick();
        req = '0;
        for (int s = 0; s < N; s++) begin
            for (int c = 0; c < HOLD; c++) begin
                total++; if (assic_seg !== msg[s] || grant !== N'(1 << s)) begin bad++; $display("FAIL sim_show s=%0d c=%0d got=%h/%b", s, c, assic_seg, grant); end
                tick();
            end
            total++; if (done !== N'(1 << s) || grant !== 3'b000) begin bad++; $display("FAIL sim_done s=%0d got=%b/%b", s, done, grant); end
            if (s < N - 1) begin
                total++; if (assic_seg !== BLANK || busy !== 1'b1) begin bad++; $display("FAIL sim_gap0 s=%0d got=%h/%b", s, assic_seg, busy); end
                tick();
                total++; if (assic_seg !== BLANK || grant !== 3'b000 || seg_point !== 8'h00) begin bad++; $display("FAIL sim_gap1 s=%0d got=%h/%b", s, assic_seg, grant); end
                tick();
            end else begin
                total++; if (assic_seg !== 64'("BACKGRND") || busy !== 1'b0) begin bad++; $display("FAIL sim_idle got=%h/%b", assic_seg, busy); end
            end
        end
    endtask

    task automatic test_refresh();
        int dones = 0;
        do_reset();
        load_slot(0, "AAAAAAAA", 8'h01);
        req = 3'b001;
        tick();
        req = '0;
        tick();
        dones += int'(done != 0);
        tick();
        dones += int'(done != 0);
        load_slot(0, "BBBBBBBB", 8'h02);
        req = 3'b001;
        tick();
        req = '0;
        dones += int'(done != 0);
        for (int c = 0; c < HOLD; c++) begin
            total++; if (assic_seg !== 64'("BBBBBBBB") || grant !== 3'b001) begin bad++; $display("FAIL refresh_show c=%0d got=%h/%b", c, assic_seg, grant); end
            tick();
            dones += int'(done != 0);
        end
        total++; if (done !== 3'b001) begin bad++; $display("FAIL refresh_done got=%b exp=001", done); end
        for (int c = 0; c < 4; c++) begin
            tick();
            dones += int'(done != 0);
        end
        total++; if (dones != 1) begin bad++; $display("FAIL refresh_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_duplicate();
        int g2 = 0;
        int d2 = 0;
        do_reset();
        load_slot(0, "SLOT-0  ", 8'h00);
        load_slot(2, "SLOT-2  ", 8'h04);
        req = 3'b001;
        tick();
        req = 3'b100;
        tick();
        req = 3'b000;
        tick();
        req = 3'b100;
        tick();
        req = 3'b000;
        for (int c = 0; c < 24; c++) begin
            g2 += int'(grant[2]);
            d2 += int'(done[2]);
            tick();
        end
        total++; if (g2 != HOLD) begin bad++; $display("FAIL dup_show_cycles got=%0d exp=%0d", g2, HOLD); end
        total++; if (d2 != 1) begin bad++; $display("FAIL dup_done_count got=%0d exp=1", d2); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dup_final_busy got=%b exp=0", busy); end
    endtask

    task automatic test_base_tracking();
        do_reset();
        base_seg = "XXXXXXXX";
        tick();
        total++; if (assic_seg !== 64'("XXXXXXXX")) begin bad++; $display("FAIL base_x got=%h", assic_seg); end
        base_seg = "YYYYYYYY";
        base_point = 8'h5a;
        tick();
        total++; if (assic_seg !== 64'("YYYYYYYY") || seg_point !== 8'h5a) begin bad++; $display("FAIL base_y got=%h/%h", assic_seg, seg_point); end
        load_slot(1, "LOCKED  ", 8'h00);
        req = 3'b010;
        tick();
        req = '0;
        base_seg = "ZZZZZZZZ";
        tick();
        tick();
        tick();
        total++; if (assic_seg !== 64'("LOCKED  ")) begin bad++; $display("FAIL base_ignored got=%h", assic_seg); end
        tick();
        total++; if (assic_seg !== 64'("ZZZZZZZZ")) begin bad++; $display("FAIL base_after got=%h", assic_seg); end
    endtask

    task automatic test_reset_mid_show();
        int g = 0;
        do_reset();
        base_seg = "RSTBASE ";
        load_slot(0, "FIRST   ", 8'h11);
        load_slot(1, "SECOND  ", 8'h22);
        req = 3'b011;
        tick();
        req = '0;
        tick();
        rstn = 1'b0;
        tick();
        total++; if (assic_seg !== BLANK || seg_point !== 8'h00) begin bad++; $display("FAIL mid_rst_seg got=%h/%h", assic_seg, seg_point); end
        total++; if (grant !== 3'b000 || busy !== 1'b0 || done !== 3'b000) begin bad++; $display("FAIL mid_rst_ctl got=%b/%b/%b", grant, busy, done); end
        rstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            g += int'(grant != 0);
        end
        total++; if (g != 0) begin bad++; $display("FAIL mid_rst_pending got=%0d grant cycles exp=0", g); end
        total++; if (assic_seg !== 64'("RSTBASE ")) begin bad++; $display("FAIL mid_rst_base got=%h", assic_seg); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rstn = ($urandom_range(0, 299) != 0);
            req = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    req[i] = 1'b1;
                    load_slot(i, {$urandom, $urandom}, 8'($urandom));
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                base_seg = {$urandom, $urandom};
                base_point = 8'($urandom);
            end
            tick();
            total++; if (assic_seg !== e_seg || seg_point !== e_pt) begin bad++; $display("FAIL rand_seg c=%0d got=%h/%h exp=%h/%h", c, assic_seg, seg_point, e_seg, e_pt); end
            total++; if (grant !== e_grant || done !== e_done || busy !== e_busy) begin bad++; $display("FAIL rand_ctl c=%0d got=%b/%b/%b exp=%b/%b/%b", c, grant, done, busy, e_grant, e_done, e_busy); end
        end
        req = '0;
        rstn = 1'b1;
    endtask

    initial begin
        m_owner = -1; m_show_left = 0; m_gap_left = 0; m_last = N - 1; m_pend = '0;
        m_cur_seg = BLANK; m_cur_pt = 8'h0;
        e_seg = BLANK; e_pt = 8'h0; e_grant = '0; e_done = '0; e_busy = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_refresh();
        test_duplicate();
        test_base_tracking();
        test_reset_mid_show();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
